load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of REQ-state cycles without mem_ack before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: req_valid  input  1  core request valid.
REQ-005 SHALL have: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have: req_funct3  input  3  RV64I width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 SHALL have: req_addr  input  64  byte address.
REQ-009 SHALL have: req_wdata  input  64  store data, LSB-justified.
REQ-010 SHALL have: rsp_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have: rsp_rdata  output  64  extended load data; 0 for stores and errors.
REQ-012 SHALL have: rsp_err  output  1  misaligned, illegal funct3 or timeout; valid with rsp_valid.
REQ-013 SHALL have: mem_req, mem_we  output  1 each  memory bus request and write flag.
REQ-014 SHALL have: mem_addr  output  64  doubleword-aligned address, bits [2:0] = 0.
REQ-015 SHALL have: mem_wdata  output  64; mem_strb  output  8  byte-lane write data and strobes.
REQ-016 SHALL have: mem_ack  input  1; mem_rdata  input  64  memory completion and doubleword read data.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL latch req_we, req_funct3, req_addr and req_wdata on req_valid & req_ready.
REQ-019 SHALL take size from funct3[1:0] (1, 2, 4, 8 bytes); misaligned means addr[log2(size)-1:0] != 0.
REQ-020 SHALL treat funct3 111, and any store with funct3[2] = 1, as illegal.
REQ-021 SHALL go IDLE->RESP with rsp_err = 1 on a misaligned or illegal request, never asserting mem_req.
REQ-022 SHALL go IDLE->REQ on a legal accepted request.
REQ-023 SHALL hold mem_req = 1 in REQ, with mem_we/mem_addr/mem_wdata/mem_strb stable until mem_ack is sampled high, then go to RESP.
REQ-024 SHALL ignore mem_ack when mem_req = 0.
REQ-025 SHALL form mem_strb as ((1<<size)-1) << addr[2:0] for stores, 8'h00 for loads.
REQ-026 SHALL form mem_wdata as req_wdata << (8*addr[2:0]).
REQ-027 SHALL compute load data as mem_rdata >> (8*addr[2:0]), truncated to size, sign-extended if funct3[2] = 0, else zero-extended, and registered at ack.
REQ-028 SHALL assert rsp_valid for exactly one cycle in RESP with no backpressure, then return to IDLE.
REQ-029 SHALL give latency as follows: accept at cycle N, mem_req from N+1, ack at cycle M gives rsp_valid at M+1; error requests give rsp_valid at N+1.

Reset
REQ-030 SHALL on rst force state IDLE; req_ready = 1; rsp_valid, rsp_err, mem_req, mem_we = 0; rsp_rdata, mem_addr, mem_wdata, mem_strb = 0; timeout counter = 0.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation, drop mem_req asynchronously and produce no response.

Configuration
REQ-032 SHALL, with LSU_TIMEOUT_EN defined, count cycles spent in REQ; when the count reaches TIMEOUT without ack, drop mem_req and go to RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-033 SHALL, without LSU_TIMEOUT_EN, omit the counter and wait in REQ indefinitely.

Verification
REQ-034 SHALL test LB at 0x1003 with mem_rdata 0x00000000_80000000, ack in the first cycle: mem_addr = 0x1000, rsp_rdata = 0xFFFFFFFF_FFFFFF80, rsp_valid 2 cycles after accept.
REQ-035 SHALL test SH at 0x2006 with wdata 0xBEEF: mem_strb = 8'hC0, mem_wdata = 0xBEEF0000_00000000, rsp_err = 0, rsp_rdata = 0.
REQ-036 SHALL test LD at 0x1004: no mem_req, rsp_valid at N+1 with rsp_err = 1; funct3 111 load gives the same result.
REQ-037 SHALL test LWU at 0x10 with ack delayed 5 cycles and mem_rdata 0x80000000_00000000 in the high half: mem_req held for 5 cycles with stable outputs, rsp_rdata = 0x00000000_00000000 (low word).
REQ-038 SHALL test rst asserted while in REQ: mem_req = 0 immediately, no rsp_valid, req_ready = 1 after release.
REQ-039 SHALL test LSU_TIMEOUT_EN with TIMEOUT = 16 and no ack: mem_req drops after 16 cycles, rsp_err = 1; without the macro, the unit stays in REQ.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The slave modport is the unit itself; the master modport is whoever drives it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_strb;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64I load/store unit: one outstanding access, doubleword memory bus with byte strobes.
// Optional REQ-state timeout abort is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  off_q, off_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_strb_q, mem_strb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;

    logic        req_bad;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT must be at least 1");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

    // Select the addressed lanes out of the doubleword, then sign- or zero-extend.
    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0] sh;
        logic [63:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   r = f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'b01:   r = f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'b10:   r = f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign req_bad = (bus.req_funct3 == 3'b111)
                   || (bus.req_we && bus.req_funct3[2])
                   || misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]);

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_strb_d  = mem_strb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    off_d    = bus.req_addr[2:0];
                    if (req_bad) begin
                        // Rejected requests never touch the memory bus.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 64'd0;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = {bus.req_addr[63:3], 3'b000};
                        mem_wdata_d = bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                        mem_strb_d  = bus.req_we
                                    ? size_mask(bus.req_funct3[1:0]) << bus.req_addr[2:0]
                                    : 8'h00;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end

            S_REQ: begin
                if (bus.mem_ack) begin
                    state_d     = S_RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = mem_we_q ? 64'd0 : load_extend(bus.mem_rdata, funct3_q, off_q);
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 64'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'd0;
            off_q       <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_strb_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_strb_q  <= mem_strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_strb  = mem_strb_q;

endmodule
